// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and small helpers for the ADC scan sequencer.
// Frame geometry follows the ADC128S022 16-clock serial frame.
package adc_pkg;

  localparam int ADC_CHANNELS = 8;
  localparam int ADC_BITS     = 12;
  localparam int FRAME_CLKS   = 16;
  localparam int ADDR_FIRST   = 3;
  localparam int DATA_FIRST   = 5;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  // Lowest enabled channel strictly above `last`, wrapping 7->0; `last` itself
  // is the lowest-priority candidate, so a single-bit mask repeats its channel.
  function automatic logic [2:0] nextChannel(input logic [ADC_CHANNELS-1:0] mask,
                                             input logic [2:0] last);
    logic [2:0] c;
    nextChannel = last;
    for (int i = ADC_CHANNELS; i >= 1; i--) begin
      c = last + 3'(i);
      if (mask[c]) nextChannel = c;
    end
  endfunction

  function automatic logic addrBit(input logic [4:0] period, input logic [2:0] addr);
    addrBit = 1'b0;
    if (period == 5'(ADDR_FIRST))          addrBit = addr[2];
    else if (period == 5'(ADDR_FIRST + 1)) addrBit = addr[1];
    else if (period == 5'(ADDR_FIRST + 2)) addrBit = addr[0];
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// Runs one 16-period SPI frame: drives sclk/din, shifts in the 12 data bits.
// done_o is high during the final cycle of the last sclk-high half-period.
module adc_spi_frame
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [2:0]          addr_i,
  input  logic                dout_i,
  output logic                sclk_o,
  output logic                din_o,
  output logic                done_o,
  output logic [ADC_BITS-1:0] data_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                active_q;
  logic                high_q;
  logic [PW-1:0]       phase_q;
  logic [4:0]          period_q;
  logic                sclk_q;
  logic                din_q;
  logic [2:0]          addr_q;
  logic [ADC_BITS-1:0] shift_q;
  logic                phaseEnd;

  assign phaseEnd = (phase_q == PW'(CLK_DIV - 1));
  assign done_o   = active_q && high_q && phaseEnd && (period_q == 5'(FRAME_CLKS));
  assign sclk_o   = sclk_q;
  assign din_o    = din_q;
  assign data_o   = shift_q;

  // Each period is CLK_DIV cycles low then CLK_DIV cycles high; din moves only
  // when sclk falls and dout is captured on the edge that raises sclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      phase_q  <= '0;
      period_q <= '0;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      addr_q   <= '0;
      shift_q  <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      high_q   <= 1'b0;
      phase_q  <= '0;
      period_q <= 5'd1;
      sclk_q   <= 1'b0;
      din_q    <= addrBit(5'd1, addr_i);
      addr_q   <= addr_i;
      shift_q  <= '0;
    end else if (active_q) begin
      if (!phaseEnd) begin
        phase_q <= phase_q + PW'(1);
      end else begin
        phase_q <= '0;
        if (!high_q) begin
          high_q <= 1'b1;
          sclk_q <= 1'b1;
          if (period_q >= 5'(DATA_FIRST)) shift_q <= {shift_q[ADC_BITS-2:0], dout_i};
        end else begin
          high_q <= 1'b0;
          if (period_q == 5'(FRAME_CLKS)) begin
            active_q <= 1'b0;
            din_q    <= 1'b0;
          end else begin
            period_q <= period_q + 5'd1;
            sclk_q   <= 1'b0;
            din_q    <= addrBit(period_q + 5'd1, addr_q);
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin scan controller for an 8-channel 12-bit serial ADC. Results are
// tagged with the address sent one frame earlier (the ADC's address pipeline).
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [ADC_CHANNELS-1:0] ch_mask,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic                    adc_din,
  input  logic                    adc_dout,
  output logic                    sample_valid,
  output logic [2:0]              sample_ch,
  output logic [ADC_BITS-1:0]     sample_data,
  input  logic [2:0]              rd_ch,
  output logic [ADC_BITS-1:0]     rd_data,
  output logic                    busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t              state_q;
  logic [PW-1:0]       phase_q;
  logic [2:0]          curCh_q;
  logic [2:0]          prevCh_q;
  logic                primed_q;
  logic                csN_q;
  logic                busy_q;
  logic                valid_q;
  logic [2:0]          sampleCh_q;
  logic [ADC_BITS-1:0] sampleData_q;
  logic [ADC_BITS-1:0] rdData_q;
  logic [ADC_BITS-1:0] regfile_q [ADC_CHANNELS];
  logic [2:0]          nextCh_d;
  logic                phaseEnd;
  logic                frameStart;
  logic                frameDone;
  logic [ADC_BITS-1:0] frameData;

  // Coming out of IDLE, rotating from channel 7 selects the lowest set bit.
  always_comb begin
    nextCh_d = nextChannel(ch_mask, (state_q == IDLE) ? 3'd7 : curCh_q);
  end

  assign phaseEnd   = (phase_q == PW'(CLK_DIV - 1));
  assign frameStart = (state_q == SETUP) && phaseEnd;

  adc_spi_frame #(.CLK_DIV(CLK_DIV)) uFrame (
    .clk     (clk),
    .rst     (rst),
    .start_i (frameStart),
    .addr_i  (curCh_q),
    .dout_i  (adc_dout),
    .sclk_o  (adc_sclk),
    .din_o   (adc_din),
    .done_o  (frameDone),
    .data_o  (frameData)
  );

  // Frame FSM plus result publication; the data of a frame belongs to the
  // channel addressed in the previous frame, so the first one is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      curCh_q      <= '0;
      prevCh_q     <= '0;
      primed_q     <= 1'b0;
      csN_q        <= 1'b1;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      sampleCh_q   <= '0;
      sampleData_q <= '0;
      rdData_q     <= '0;
      for (int i = 0; i < ADC_CHANNELS; i++) regfile_q[i] <= '0;
    end else begin
      valid_q  <= 1'b0;
      rdData_q <= regfile_q[rd_ch];
      case (state_q)
        IDLE: begin
          if (enable && (ch_mask != '0)) begin
            state_q <= SETUP;
            phase_q <= '0;
            curCh_q <= nextCh_d;
            csN_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (phaseEnd) begin
            state_q <= SHIFT;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        SHIFT: begin
          if (frameDone) begin
            state_q  <= QUIET;
            phase_q  <= '0;
            csN_q    <= 1'b1;
            busy_q   <= 1'b0;
            prevCh_q <= curCh_q;
            primed_q <= 1'b1;
            if (primed_q) begin
              valid_q             <= 1'b1;
              sampleCh_q          <= prevCh_q;
              sampleData_q        <= frameData;
              regfile_q[prevCh_q] <= frameData;
            end
          end
        end
        QUIET: begin
          if (phaseEnd) begin
            phase_q <= '0;
            if (enable && (ch_mask != '0)) begin
              state_q <= SETUP;
              curCh_q <= nextCh_d;
              csN_q   <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q  <= IDLE;
              primed_q <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_cs_n     = csN_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_ch    = sampleCh_q;
  assign sample_data  = sampleData_q;
  assign rd_data      = rdData_q;

endmodule
